// File: rtl/data_memory_kbd.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_kbd
// Description : Word-addressed 32-bit data memory with byte-lane writes and
//               a registered read port. A keyboard capture FSM deposits
//               three make codes plus valid flags into a mailbox region.
//               An overflow counter tracks codes dropped while the mailbox
//               is full. The CPU re-arms capture by writing the ready word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_kbd #(
    parameter int DEPTH     = 512,
    parameter int MBOX_BASE = 33,
    parameter int DEBUG_IDX = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEn,
    input  logic        newchar,
    input  logic [15:0] char,
    output logic [31:0] MemData,
    output logic [31:0] a3
);

    localparam int              c_aw       = $clog2(DEPTH);
    localparam logic [31:0]     c_depth    = 32'(DEPTH);
    localparam logic [c_aw-1:0] c_idx_num1 = c_aw'(MBOX_BASE + 0);
    localparam logic [c_aw-1:0] c_idx_num2 = c_aw'(MBOX_BASE + 1);
    localparam logic [c_aw-1:0] c_idx_op   = c_aw'(MBOX_BASE + 2);
    localparam logic [c_aw-1:0] c_idx_f1   = c_aw'(MBOX_BASE + 3);
    localparam logic [c_aw-1:0] c_idx_f2   = c_aw'(MBOX_BASE + 4);
    localparam logic [c_aw-1:0] c_idx_rdy  = c_aw'(MBOX_BASE + 5);
    localparam logic [c_aw-1:0] c_idx_cnt  = c_aw'(MBOX_BASE + 6);
    localparam logic [c_aw-1:0] c_idx_dbg  = c_aw'(DEBUG_IDX);

    typedef enum logic [1:0] {
        S_NUM1 = 2'd0,
        S_NUM2 = 2'd1,
        S_OP   = 2'd2,
        S_FULL = 2'd3
    } state_t;

    logic [31:0]     r_mem [DEPTH];
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_aw-1:0] w_idx;
    logic            w_addr_ok;
    logic            w_cpu_wr;
    logic            w_acc;
    logic            w_rearm;
    logic [7:0]      w_cnt_cur;
    logic [7:0]      w_cnt_inc;

    assign w_idx     = Address[c_aw-1:0];
    assign w_addr_ok = (Address < c_depth);
    // Reads take priority over writes addressed in the same cycle.
    assign w_cpu_wr  = MemWrite && !MemRead && w_addr_ok;
    // Break codes (F0 prefix) never reach the capture logic.
    assign w_acc     = newchar && (char[15:8] != 8'hF0);
    assign w_rearm   = w_cpu_wr && (w_idx == c_idx_rdy);
    assign w_cnt_cur = r_mem[c_idx_cnt][7:0];
    assign w_cnt_inc = (w_cnt_cur == 8'hFF) ? 8'hFF : w_cnt_cur + 8'd1;
    assign a3        = r_mem[c_idx_dbg];

    // Capture state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_NUM1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: re-arm overrides any coincident code.
    always_comb begin
        w_state_nxt = r_state;
        if (w_rearm) begin
            w_state_nxt = S_NUM1;
        end else if (w_acc) begin
            case (r_state)
                S_NUM1:  w_state_nxt = S_NUM2;
                S_NUM2:  w_state_nxt = S_OP;
                S_OP:    w_state_nxt = S_FULL;
                default: w_state_nxt = S_FULL;
            endcase
        end
    end

    // Registered read port; returns the pre-update word contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemData <= '0;
        end else if (MemRead && w_addr_ok) begin
            MemData <= r_mem[w_idx];
        end else begin
            MemData <= '0;
        end
    end

    // Storage: CPU byte writes first, keyboard/mailbox updates afterwards so
    // they win when both target the same word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_cpu_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (ByteEn[b]) begin
                        r_mem[w_idx][8*b +: 8] <= WriteData[8*b +: 8];
                    end
                end
            end
            if (w_rearm) begin
                r_mem[c_idx_f1]  <= '0;
                r_mem[c_idx_f2]  <= '0;
                r_mem[c_idx_rdy] <= '0;
            end else if (w_acc) begin
                case (r_state)
                    S_NUM1: begin
                        r_mem[c_idx_num1] <= {24'b0, char[7:0]};
                        r_mem[c_idx_f1]   <= 32'd1;
                    end
                    S_NUM2: begin
                        r_mem[c_idx_num2] <= {24'b0, char[7:0]};
                        r_mem[c_idx_f2]   <= 32'd1;
                    end
                    S_OP: begin
                        r_mem[c_idx_op]  <= {24'b0, char[7:0]};
                        r_mem[c_idx_rdy] <= 32'd1;
                    end
                    default: ;
                endcase
            end
            // A code arriving while full is counted even if re-arm coincides.
            if (w_acc && (r_state == S_FULL)) begin
                r_mem[c_idx_cnt] <= {24'b0, w_cnt_inc};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_kbd.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_kbd
// Description : Directed vector bench for data_memory_kbd (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_kbd;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic        newchar;
    logic [15:0] char;
    logic [31:0] MemData;
    logic [31:0] a3;

    int errors = 0;
    int checks = 0;

    data_memory_kbd dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ByteEn    (ByteEn),
        .newchar   (newchar),
        .char      (char),
        .MemData   (MemData),
        .a3        (a3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        nc;
        logic [15:0] ch;
        logic [31:0] exp_md;
        logic [31:0] exp_a3;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        ByteEn    = '0;
        newchar   = 1'b0;
        char      = '0;
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic nc, input logic [15:0] ch);
        MemRead   = rd;
        MemWrite  = wr;
        Address   = ad;
        WriteData = wd;
        ByteEn    = be;
        newchar   = nc;
        char      = ch;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [31:0] ad, input logic [31:0] exp, input string name);
        cyc(1'b1, 1'b0, ad, 32'h0, 4'h0, 1'b0, 16'h0);
        check(name, MemData, exp);
    endtask

    task automatic code(input logic [15:0] ch);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, ch);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'd10,  32'hDEADBEEF, 4'hF, 1'b0, 16'h0000, 32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'd10,  32'h0,        4'h0, 1'b0, 16'h0000, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'd10,  32'h11223344, 4'h5, 1'b0, 16'h0000, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'd10,  32'h0,        4'h0, 1'b0, 16'h0000, 32'hDE22BE44, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'd7,   32'hCAFE0001, 4'hF, 1'b0, 16'h0000, 32'h0,        32'hCAFE0001};
        vecs[6]  = '{1'b1, 1'b1, 32'd7,   32'h00000005, 4'hF, 1'b0, 16'h0000, 32'hCAFE0001, 32'hCAFE0001};
        vecs[7]  = '{1'b1, 1'b0, 32'd7,   32'h0,        4'h0, 1'b0, 16'h0000, 32'hCAFE0001, 32'hCAFE0001};
        vecs[8]  = '{1'b0, 1'b1, 32'd512, 32'hFFFFFFFF, 4'hF, 1'b0, 16'h0000, 32'h0,        32'hCAFE0001};
        vecs[9]  = '{1'b1, 1'b0, 32'd512, 32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        32'hCAFE0001};
        vecs[10] = '{1'b1, 1'b0, 32'd0,   32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        32'hCAFE0001};
        vecs[11] = '{1'b1, 1'b0, 32'd33,  32'h0,        4'h0, 1'b1, 16'h0016, 32'h0,        32'hCAFE0001};
        vecs[12] = '{1'b1, 1'b0, 32'd33,  32'h0,        4'h0, 1'b1, 16'hF016, 32'h16,       32'hCAFE0001};
        vecs[13] = '{1'b1, 1'b0, 32'd36,  32'h0,        4'h0, 1'b1, 16'h001E, 32'h1,        32'hCAFE0001};
        vecs[14] = '{1'b1, 1'b0, 32'd34,  32'h0,        4'h0, 1'b1, 16'h0079, 32'h1E,       32'hCAFE0001};
        vecs[15] = '{1'b1, 1'b0, 32'd35,  32'h0,        4'h0, 1'b0, 16'h0000, 32'h79,       32'hCAFE0001};
        vecs[16] = '{1'b1, 1'b0, 32'd37,  32'h0,        4'h0, 1'b0, 16'h0000, 32'h1,        32'hCAFE0001};
        vecs[17] = '{1'b1, 1'b0, 32'd38,  32'h0,        4'h0, 1'b0, 16'h0000, 32'h1,        32'hCAFE0001};
        vecs[18] = '{1'b1, 1'b0, 32'd39,  32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        32'hCAFE0001};

        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_memdata", MemData, 32'h0);
        check("reset_a3", a3, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be,
                vecs[i].nc, vecs[i].ch);
            check($sformatf("vec%0d_memdata", i), MemData, vecs[i].exp_md);
            check($sformatf("vec%0d_a3", i), a3, vecs[i].exp_a3);
        end

        // Mailbox full: 300 codes saturate the overflow counter.
        for (int i = 0; i < 300; i++) begin
            code(16'h0022);
        end
        rd(32'd39, 32'hFF, "ovf_saturated");
        rd(32'd33, 32'h16, "full_num1_kept");

        // Re-arm by writing the ready word.
        cyc(1'b0, 1'b1, 32'd38, 32'h0, 4'hF, 1'b0, 16'h0);
        rd(32'd36, 32'h0, "rearm_f1");
        rd(32'd37, 32'h0, "rearm_f2");
        rd(32'd38, 32'h0, "rearm_rdy");
        rd(32'd39, 32'hFF, "rearm_ovf_kept");
        code(16'h0045);
        rd(32'd33, 32'h45, "after_rearm_num1");
        rd(32'd36, 32'h1, "after_rearm_f1");

        // Re-arm with ByteEn=0 plus coincident code while not full: dropped.
        cyc(1'b0, 1'b1, 32'd38, 32'h0, 4'h0, 1'b1, 16'h0050);
        rd(32'd36, 32'h0, "rearm_be0_f1");
        rd(32'd34, 32'h1E, "rearm_code_dropped");
        rd(32'd39, 32'hFF, "rearm_code_uncounted");
        code(16'h0051);
        rd(32'd33, 32'h51, "rearm_restart_num1");

        // Keyboard write beats CPU write to the same word.
        cyc(1'b0, 1'b1, 32'd34, 32'hAAAAAAAA, 4'hF, 1'b1, 16'h0060);
        rd(32'd34, 32'h60, "kbd_beats_cpu");
        rd(32'd37, 32'h1, "kbd_f2");
        code(16'h0061);
        rd(32'd35, 32'h61, "op_code");
        rd(32'd38, 32'h1, "ready_set");

        // CPU writes the counter, then re-arm coincides with a code in S_FULL.
        cyc(1'b0, 1'b1, 32'd39, 32'h00000010, 4'h1, 1'b0, 16'h0);
        rd(32'd39, 32'h10, "ovf_cpu_write");
        cyc(1'b0, 1'b1, 32'd38, 32'h0, 4'hF, 1'b1, 16'h0062);
        rd(32'd39, 32'h11, "rearm_full_counted");
        rd(32'd38, 32'h0, "rearm_full_rdy");
        rd(32'd35, 32'h61, "rearm_full_op_kept");
        code(16'h0070);
        rd(32'd33, 32'h70, "post_rearm_num1");

        // Asynchronous reset mid-sequence, with activity held during reset.
        MemWrite  = 1'b1;
        Address   = 32'd10;
        WriteData = 32'h1;
        ByteEn    = 4'hF;
        newchar   = 1'b1;
        char      = 16'h0040;
        reset     = 1'b1;
        #1;
        check("async_reset_memdata", MemData, 32'h0);
        check("async_reset_a3", a3, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        rd(32'd10, 32'h0, "post_reset_w10");
        rd(32'd33, 32'h0, "post_reset_w33");
        rd(32'd39, 32'h0, "post_reset_w39");
        rd(32'd36, 32'h0, "post_reset_w36");
        code(16'h0033);
        rd(32'd33, 32'h33, "restart_num1");
        rd(32'd36, 32'h1, "restart_f1");
        rd(32'd37, 32'h0, "restart_f2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
